// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC owner with in-order imem requests and a small fetch queue
// feeding the IF/ID register. Revision 1.0.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] jb_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] current_pc,
  output logic        inst_valid
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW:0] C_DEPTH = QDEPTH[CW:0];

  // Entries are filled in program order, so "filled" is the prefix of
  // fill_cnt entries starting at head; pending is the rest of the allocation.
  logic [31:0]   pc_q   [QDEPTH];
  logic [31:0]   data_q [QDEPTH];
  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] drop_cnt;

  logic [CW-1:0] pending;
  logic [CW:0]   occupancy;
  logic [PW-1:0] tail_idx;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] head_nxt;
  logic          redirect;
  logic          grant;
  logic          pop;
  logic          resp_fill;
  logic          resp_drop;

  function automatic logic [PW-1:0] wrap_idx(input logic [31:0] base, input logic [31:0] off);
    logic [31:0] sum;
    sum = base + off;
    if (sum >= 32'(QDEPTH)) sum = sum - 32'(QDEPTH);
    return sum[PW-1:0];
  endfunction

  assign pending   = alloc_cnt - fill_cnt;
  assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign tail_idx  = wrap_idx(32'(head), 32'(alloc_cnt));
  assign fill_idx  = wrap_idx(32'(head), 32'(fill_cnt));
  assign head_nxt  = wrap_idx(32'(head), 32'd1);

  assign redirect  = jb && !stall;
  // Occupancy uses registered counts, so a pop never frees a slot for a
  // same-cycle request.
  assign imem_req  = !rst && (occupancy < C_DEPTH) && !redirect;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign inst_valid = (fill_cnt != '0);
  assign pop        = inst_valid && !stall && !jb;
  assign resp_drop  = imem_rvalid && (drop_cnt != '0);
  assign resp_fill  = imem_rvalid && (drop_cnt == '0) && (pending != '0);

  assign inst       = inst_valid ? data_q[head] : NOP_INST;
  assign current_pc = inst_valid ? pc_q[head]   : 32'h0000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      head      <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect) begin
      // Everything still in flight now belongs to the wrong path.
      pc        <= jb_pc;
      head      <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
      drop_cnt  <= drop_cnt + pending - CW'(imem_rvalid);
    end else begin
      if (grant) pc <= pc + 32'd4;
      if (pop) head <= head_nxt;
      alloc_cnt <= alloc_cnt + CW'(grant) - CW'(pop);
      fill_cnt  <= fill_cnt + CW'(resp_fill) - CW'(pop);
      drop_cnt  <= drop_cnt - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (grant)     pc_q[tail_idx]   <= pc;
    if (resp_fill) data_q[fill_idx] <= imem_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an epoch-tagged memory and stream-level reference model.
`default_nettype none

module tb_fetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jb = 1'b0;
  logic [31:0] jb_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] current_pc;
  logic        inst_valid;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jb(jb), .jb_pc(jb_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .current_pc(current_pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } rsp_t;

  rsp_t        memq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          lat_max = 1;
  logic [31:0] req_pc = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a falling edge: drive, check, advance the model, move to the next falling edge.
  task automatic cycle(input logic s, input logic j, input logic [31:0] jp, input logic g);
    logic exp_req, rv, pop, got;
    rsp_t e;
    stall    = s;
    jb       = j;
    jb_pc    = jp;
    imem_gnt = g;
    rv = (memq.size() > 0) && (memq[0].ready <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(memq[0].addr) : $urandom();
    #1;
    exp_req = (memq.size() + buffered < QDEPTH) && !(j && !s);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, req_pc);
    chk("inst_valid", 32'(inst_valid), 32'(buffered > 0));
    if (buffered > 0) begin
      chk("current_pc", current_pc, exp_pc);
      chk("inst", inst, mem_word(exp_pc));
    end else begin
      chk("nop_inst", inst, NOP_INST);
      chk("nop_pc", current_pc, 32'h0);
    end
    pop = (buffered > 0) && !s && !j;
    got = 1'b0;
    if (rv) begin
      e = memq.pop_front();
      got = (e.epoch == epoch);
    end
    if (pop) begin
      buffered--;
      exp_pc = exp_pc + 32'd4;
    end
    if (got) buffered++;
    if (exp_req && g) begin
      memq.push_back('{req_pc, epoch, cyc + int'($urandom_range(1, lat_max))});
      req_pc = req_pc + 32'd4;
    end
    if (j && !s) begin
      epoch++;
      buffered = 0;
      req_pc   = jp;
      exp_pc   = jp;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asserted between edges so the outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_inst", inst, NOP_INST);
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    memq.delete();
    epoch++;
    buffered    = 0;
    req_pc      = RESET_PC;
    exp_pc      = RESET_PC;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    jb          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        s, j, g;
    logic [31:0] jp;
    @(negedge clk);
    do_reset();

    lat_max = 1;
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    cycle(1'b0, 1'b1, 32'h300, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    lat_max = 3;
    repeat (3000) begin
      s  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 15) == 0);
      jp = $urandom();
      jp = jp & 32'hFFFF_FFFC;
      g  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(s, j, jp, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
